// File: rtl/sqrt_pkg.sv
// Shared types, Q4.4 constants and arithmetic helpers for the Heron square-root controller.
package sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] Q44_ONE = 8'h10;
    localparam logic [7:0] Q44_SAT = 8'hFF;
    localparam int         UPD_W   = 13;

    // Coarse initial estimate chosen from the radicand's leading bit pairs.
    function automatic logic [7:0] seed_f(input logic [7:0] a);
        logic [7:0] s;
        if (a[7:6] != 2'b00) begin
            s = 8'h80;
        end else if (a[5:4] != 2'b00) begin
            s = 8'h40;
        end else begin
            s = 8'h20;
        end
        return s;
    endfunction

    // One Heron step in Q4.4: average the estimate with the integer quotient, saturate, never zero.
    function automatic logic [7:0] update_f(input logic [7:0] x, input logic [7:0] q);
        logic [UPD_W-1:0] sum;
        logic [UPD_W-1:0] half;
        logic [7:0]       res;
        sum  = UPD_W'(x) + (UPD_W'(q) * UPD_W'(Q44_ONE));
        half = sum >> 1;
        if (half > UPD_W'(Q44_SAT)) begin
            res = Q44_SAT;
        end else begin
            res = half[7:0];
        end
        if (res == 8'h00) begin
            res = 8'h01;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/heron_sqrt_ctrl.sv
// Iterative Heron square-root controller: drives an external combinational divider and
// converges an 8-bit radicand to a Q4.4 root with valid/ready handshakes on both sides.
module heron_sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_root,
    output logic [3:0] out_iters,
    output logic [7:0] div_n,
    output logic [7:0] div_d,
    input  logic [7:0] div_q
);

    localparam logic [3:0] MAX_ITER_C = 4'(MAX_ITER);

    state_t     state_r;
    logic [7:0] x_r;
    logic [7:0] q_r;
    logic [3:0] iter_r;

    logic [7:0] xn_s;
    logic [7:0] delta_s;
    logic [3:0] iter_nxt_s;
    logic       term_s;

    // Next estimate and convergence test, evaluated on the saturated estimate.
    always_comb begin
        xn_s       = update_f(x_r, q_r);
        iter_nxt_s = iter_r + 4'd1;
        if (xn_s > x_r) begin
            delta_s = xn_s - x_r;
        end else begin
            delta_s = x_r - xn_s;
        end
        if ((delta_s <= 8'd1) || (iter_nxt_s == MAX_ITER_C)) begin
            term_s = 1'b1;
        end else begin
            term_s = 1'b0;
        end
    end

    // Control FSM with all handshake and divider outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_root  <= 8'h00;
            out_iters <= 4'd0;
            div_n     <= 8'h00;
            div_d     <= 8'h01;
            x_r       <= 8'h01;
            q_r       <= 8'h00;
            iter_r    <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (in_a == 8'h00) begin
                            out_root  <= 8'h00;
                            out_iters <= 4'd0;
                            out_valid <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            x_r     <= seed_f(in_a);
                            div_n   <= in_a;
                            div_d   <= seed_f(in_a);
                            iter_r  <= 4'd0;
                            state_r <= ST_CAPTURE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    q_r     <= div_q;
                    state_r <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    iter_r <= iter_nxt_s;
                    if (term_s) begin
                        out_root  <= xn_s;
                        out_iters <= iter_nxt_s;
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        x_r     <= xn_s;
                        div_d   <= xn_s;
                        state_r <= ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here keeps the next accept at least one cycle after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
